instr_reader: RTL

- Read-side engine for the instruction register. The testbench/loader fills the register through the write port.
- On a start command, this block walks read_pointer over a contiguous range of entries and captures each instruction word (opcode, operand_a, operand_b).
- Computes each result and presents (pointer, opcode, result) on a valid/ready output stream.
- Sits between the instr_register read port and downstream checkers/scoreboards.

---
 rtl/instr_reader.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/instr_reader.sv
// Read-side engine for the instruction register: walks a range of entries,
// executes each instruction and streams (pointer, opcode, result) over valid/ready.
module instr_reader #(
    parameter int NUM_REGS = 32,
    parameter int PTR_W    = $clog2(NUM_REGS),
    parameter int OP_W     = 32,
    parameter int OPC_W    = 4,
    parameter int RES_W    = 2 * OP_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [PTR_W-1:0]        start_ptr,
    input  logic [PTR_W:0]          count,
    output logic [PTR_W-1:0]        read_pointer,
    input  logic [OPC_W-1:0]        instr_opcode,
    input  logic signed [OP_W-1:0]  instr_op_a,
    input  logic signed [OP_W-1:0]  instr_op_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [PTR_W-1:0]        out_ptr,
    output logic [OPC_W-1:0]        out_opcode,
    output logic signed [RES_W-1:0] out_result,
    output logic                    out_div0,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        OUT,
        DONE
    } state_t;

    localparam logic [OPC_W-1:0] OPC_ZERO  = OPC_W'(0);
    localparam logic [OPC_W-1:0] OPC_PASSA = OPC_W'(1);
    localparam logic [OPC_W-1:0] OPC_PASSB = OPC_W'(2);
    localparam logic [OPC_W-1:0] OPC_ADD   = OPC_W'(3);
    localparam logic [OPC_W-1:0] OPC_SUB   = OPC_W'(4);
    localparam logic [OPC_W-1:0] OPC_MULT  = OPC_W'(5);
    localparam logic [OPC_W-1:0] OPC_DIV   = OPC_W'(6);
    localparam logic [OPC_W-1:0] OPC_MOD   = OPC_W'(7);

    localparam logic [PTR_W:0]   MAX_COUNT = (PTR_W + 1)'(NUM_REGS);
    localparam logic [PTR_W:0]   REM_ONE   = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    state_t state;
    state_t state_next;

    logic [PTR_W-1:0]        ptr;
    logic [PTR_W:0]          remaining;
    logic [PTR_W:0]          count_clamped;
    logic [OPC_W-1:0]        opcode_q;
    logic signed [OP_W-1:0]  op_a_q;
    logic signed [OP_W-1:0]  op_b_q;
    logic signed [RES_W-1:0] a_ext;
    logic signed [RES_W-1:0] b_ext;
    logic signed [RES_W-1:0] result_calc;
    logic                    div0_calc;
    logic                    handshake;

    assign handshake     = out_valid && out_ready;
    assign count_clamped = (count > MAX_COUNT) ? MAX_COUNT : count;
    assign read_pointer  = ptr;
    assign busy          = (state != IDLE);
    assign done          = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = (count == '0) ? DONE : FETCH;
            FETCH:   state_next = EXEC;
            EXEC:    state_next = OUT;
            OUT:     if (handshake) state_next = (remaining == REM_ONE) ? DONE : FETCH;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Arithmetic is done at full result width so MULT keeps the whole product.
    assign a_ext = {{(RES_W - OP_W){op_a_q[OP_W-1]}}, op_a_q};
    assign b_ext = {{(RES_W - OP_W){op_b_q[OP_W-1]}}, op_b_q};

    always_comb begin
        result_calc = '0;
        div0_calc   = 1'b0;
        case (opcode_q)
            OPC_ZERO:  result_calc = '0;
            OPC_PASSA: result_calc = a_ext;
            OPC_PASSB: result_calc = b_ext;
            OPC_ADD:   result_calc = a_ext + b_ext;
            OPC_SUB:   result_calc = a_ext - b_ext;
            OPC_MULT:  result_calc = a_ext * b_ext;
            OPC_DIV: begin
                if (op_b_q == '0) div0_calc = 1'b1;
                else              result_calc = a_ext / b_ext;
            end
            OPC_MOD: begin
                if (op_b_q == '0) div0_calc = 1'b1;
                else              result_calc = a_ext % b_ext;
            end
            default:   result_calc = '0;
        endcase
    end

    // ptr only moves when entering FETCH, so read_pointer holds elsewhere.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr        <= '0;
            remaining  <= '0;
            opcode_q   <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            out_valid  <= 1'b0;
            out_ptr    <= '0;
            out_opcode <= '0;
            out_result <= '0;
            out_div0   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && count != '0) begin
                        ptr       <= start_ptr;
                        remaining <= count_clamped;
                    end
                end
                FETCH: begin
                    opcode_q <= instr_opcode;
                    op_a_q   <= instr_op_a;
                    op_b_q   <= instr_op_b;
                end
                EXEC: begin
                    out_valid  <= 1'b1;
                    out_ptr    <= ptr;
                    out_opcode <= opcode_q;
                    out_result <= result_calc;
                    out_div0   <= div0_calc;
                end
                OUT: begin
                    if (handshake) begin
                        out_valid <= 1'b0;
                        remaining <= remaining - REM_ONE;
                        if (remaining != REM_ONE) ptr <= ptr + PTR_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
